pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Merges the decoder's
//  load-use stall request, multi-cycle EX operations (div/mul) and flush requests
//  (exception/branch redirect) into one per-stage stall vector plus a flush/new-PC
//  pulse. Sits beside the pipeline registers; drives their hold and clear inputs.
// PARAMETERS
//  CNT_W         6   width of the EX multi-cycle counter and ex_cycles
//  FLUSH_CYCLES  1   cycles flush stays high per flush request (>=1)
// PORTS
//  clk              in   1      clock, all state on rising edge
//  rst              in   1      synchronous reset, active-high
//  stallreq_id      in   1      decoder load-use hazard, level, valid every cycle
//  ex_start         in   1      EX begins a multi-cycle op, 1-cycle pulse
//  ex_cycles        in   CNT_W  total EX cycles K of that op, sampled with ex_start
//  flush_req        in   1      redirect/exception request, 1-cycle pulse
//  flush_pc         in   32     target PC, sampled with flush_req
//  stall            out  6      hold per stage: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
//  flush            out  1      clear all pipeline registers, load new_pc
//  new_pc           out  32     redirect target, valid while flush=1
//  ex_busy          out  1      multi-cycle EX op in progress
//  ex_done          out  1      1-cycle pulse: multi-cycle result valid in EX
// BEHAVIOUR
//  Reset: state=RUN, cnt=0, flush=0, new_pc=0, ex_busy=0, ex_done=0. stall=0
//   while rst=1, including the cycle rst is asserted.
//  FSM states: RUN, EX_WAIT, FLUSH. flush/new_pc/ex_done registered; stall and
//   ex_busy decoded combinationally from state (and stallreq_id in RUN).
//  RUN: stall = stallreq_id ? 6'b000111 : 6'b000000. Priority at the clock edge:
//   1. flush_req: new_pc<=flush_pc, fcnt<=FLUSH_CYCLES, go FLUSH.
//   2. ex_start with ex_cycles>=2: cnt<=ex_cycles-1, go EX_WAIT.
//   3. else stay in RUN. ex_start with ex_cycles 0 or 1 is a single-cycle op:
//      no state change, no ex_done.
//  EX_WAIT: stall=6'b001111, ex_busy=1, stallreq_id ignored. cnt decrements each
//   cycle; at cnt==1 go RUN and set ex_done=1 for exactly one cycle.
//   ex_start at cycle N with K>=2 -> EX_WAIT cycles N+1..N+K-1 (K-1 stall
//   cycles), ex_done=1 and state RUN at cycle N+K.
//   flush_req in EX_WAIT aborts the op: go FLUSH, cnt<=0, ex_done stays 0.
//   ex_start in EX_WAIT is ignored (EX is held, cannot issue).
//  FLUSH: flush=1, stall=0, ex_busy=0. fcnt decrements each cycle; at fcnt==1 go
//   RUN, flush<=0. flush_req at cycle N -> flush=1 in cycles N+1..N+FLUSH_CYCLES.
//   flush_req during FLUSH re-latches new_pc and reloads fcnt (newest wins).
//   ex_start and stallreq_id are ignored during FLUSH.
//  ex_done and flush never assert in the same cycle. ex_done=1 only in RUN.
//  rst mid-operation (EX_WAIT or FLUSH): next cycle is the reset state; a pending
//   ex_done or flush is dropped, no output glitch beyond the rst cycle.
//  Counters never wrap: cnt is loaded only with values >= 1; K=2^CNT_W-1 is legal.
// TESTING
//  1 stallreq_id=1 for 3 cycles in RUN -> stall=000111 for exactly those 3
//    cycles, flush=0, ex_busy=0.
//  2 ex_start, ex_cycles=5 at cycle 10 -> stall=001111, ex_busy=1 cycles 11-14;
//    ex_done=1 only in cycle 15; stall=0 in cycle 15.
//  3 ex_start, ex_cycles=1, then ex_cycles=0 -> no stall, no ex_done, state RUN.
//  4 ex_cycles=8 at cycle 0, flush_req with flush_pc=32'h0000_0100 at cycle 3 ->
//    flush=1, new_pc=0x100 in cycle 4, ex_done never pulses, stall=0 from cycle 4.
//  5 FLUSH_CYCLES=2; flush_req pc=0x20 at cycle 0, pc=0x40 at cycle 1 ->
//    flush=1 cycles 1-3, new_pc=0x20 in cycle 1, 0x40 in cycles 2-3.
//  6 rst=1 in cycle 3 of a K=6 EX wait -> all outputs 0 in cycle 3 and following
//    cycle; no ex_done afterwards; stallreq_id then works as in scenario 1.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline.
// It merges three kinds of request into one per-stage hold vector and a flush/redirect pulse:
// the decoder load-use stall, multi-cycle EX operations, and redirect/exception flushes.
//
// Ports
//   clk, rst     clock and synchronous active-high reset
//   stallreq_id  load-use hazard from the decoder (level)
//   ex_start     pulse that starts a multi-cycle EX op; ex_cycles holds its total length K
//   flush_req    redirect pulse; flush_pc holds its target
//   stall[5:0]   hold per stage: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
//   flush        clears all pipeline registers; new_pc is valid while flush=1
//   ex_busy      a multi-cycle op is in progress
//   ex_done      one-cycle pulse when the multi-cycle result is valid
//
// state   | meaning
// ST_RUN  | normal flow, only load-use stalls
// ST_EXW  | multi-cycle EX op counting down, front end and EX held
// ST_FLSH | flush asserted for FLUSH_CYCLES cycles
module pipeline_ctrl #(
    parameter int CNT_W        = 6,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             ex_start,
    input  logic [CNT_W-1:0] ex_cycles,
    input  logic             flush_req,
    input  logic [31:0]      flush_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             ex_busy,
    output logic             ex_done
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {ST_RUN, ST_EXW, ST_FLSH} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [FW-1:0]    fcnt, fcnt_nxt;
    logic [31:0]      new_pc_nxt;
    logic             flush_nxt;
    logic             ex_done_nxt;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        fcnt_nxt    = fcnt;
        new_pc_nxt  = new_pc;
        flush_nxt   = 1'b0;
        ex_done_nxt = 1'b0;
        stall       = 6'b000000;
        ex_busy     = 1'b0;

        case (state)
            ST_RUN: begin
                stall = stallreq_id ? 6'b000111 : 6'b000000;
                if (flush_req) begin
                    new_pc_nxt = flush_pc;
                    fcnt_nxt   = FW'(FLUSH_CYCLES);
                    flush_nxt  = 1'b1;
                    state_nxt  = ST_FLSH;
                end else if (ex_start && (ex_cycles >= CNT_W'(2))) begin
                    // K-1 held cycles follow; K of 0 or 1 is a single-cycle op
                    cnt_nxt   = ex_cycles - CNT_W'(1);
                    state_nxt = ST_EXW;
                end
            end
            ST_EXW: begin
                stall   = 6'b001111;
                ex_busy = 1'b1;
                if (flush_req) begin
                    // a redirect aborts the op; its result is never reported
                    new_pc_nxt = flush_pc;
                    fcnt_nxt   = FW'(FLUSH_CYCLES);
                    flush_nxt  = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = ST_FLSH;
                end else if (cnt == CNT_W'(1)) begin
                    cnt_nxt     = '0;
                    ex_done_nxt = 1'b1;
                    state_nxt   = ST_RUN;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_FLSH: begin
                if (flush_req) begin
                    // the newest redirect wins and restarts the flush window
                    new_pc_nxt = flush_pc;
                    fcnt_nxt   = FW'(FLUSH_CYCLES);
                    flush_nxt  = 1'b1;
                end else if (fcnt == FW'(1)) begin
                    fcnt_nxt  = '0;
                    state_nxt = ST_RUN;
                end else begin
                    fcnt_nxt  = fcnt - FW'(1);
                    flush_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase

        // holds must drop in the very cycle reset is applied, before state clears
        if (rst) begin
            stall   = 6'b000000;
            ex_busy = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RUN;
            cnt     <= '0;
            fcnt    <= '0;
            new_pc  <= '0;
            flush   <= 1'b0;
            ex_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            fcnt    <= fcnt_nxt;
            new_pc  <= new_pc_nxt;
            flush   <= flush_nxt;
            ex_done <= ex_done_nxt;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. Two instances share the stimulus:
// d1 uses FLUSH_CYCLES=1 and d2 uses FLUSH_CYCLES=2.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        ex_start;
    logic [5:0]  ex_cycles;
    logic        flush_req;
    logic [31:0] flush_pc;

    logic [5:0]  stall1, stall2;
    logic        flush1, flush2;
    logic [31:0] new_pc1, new_pc2;
    logic        ex_busy1, ex_busy2;
    logic        ex_done1, ex_done2;

    int total = 0;
    int bad   = 0;

    pipeline_ctrl #(.CNT_W(6), .FLUSH_CYCLES(1)) d1 (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_start(ex_start),
        .ex_cycles(ex_cycles), .flush_req(flush_req), .flush_pc(flush_pc),
        .stall(stall1), .flush(flush1), .new_pc(new_pc1), .ex_busy(ex_busy1),
        .ex_done(ex_done1));

    pipeline_ctrl #(.CNT_W(6), .FLUSH_CYCLES(2)) d2 (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_start(ex_start),
        .ex_cycles(ex_cycles), .flush_req(flush_req), .flush_pc(flush_pc),
        .stall(stall2), .flush(flush2), .new_pc(new_pc2), .ex_busy(ex_busy2),
        .ex_done(ex_done2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // advance to the next cycle; inputs get set and outputs checked mid-cycle
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        stallreq_id = 0; ex_start = 0; ex_cycles = 0; flush_req = 0; flush_pc = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle(); stallreq_id = 1;
        #1;
        total++;
        if (stall1 !== 6'b0 || stall2 !== 6'b0) begin
            bad++; $display("FAIL reset_stall_comb: got %b/%b want 000000", stall1, stall2);
        end
        cyc(); #1;
        total++;
        if (stall1 !== 6'b0 || ex_busy1 !== 1'b0) begin
            bad++; $display("FAIL reset_hold: stall=%b busy=%b want 0", stall1, ex_busy1);
        end
        cyc(); rst = 0; stallreq_id = 0; #1;
        total++;
        if ({stall1, flush1, ex_busy1, ex_done1} !== 9'b0 || new_pc1 !== 32'h0) begin
            bad++; $display("FAIL reset_state: stall=%b fl=%b busy=%b done=%b pc=%h want 0",
                            stall1, flush1, ex_busy1, ex_done1, new_pc1);
        end
        cyc();
    endtask

    task automatic test_loaduse();
        for (int i = 0; i < 3; i++) begin
            stallreq_id = 1; #1;
            total++;
            if (stall1 !== 6'b000111 || flush1 !== 1'b0 || ex_busy1 !== 1'b0) begin
                bad++; $display("FAIL loaduse_c%0d: stall=%b fl=%b busy=%b want 000111 0 0",
                                i, stall1, flush1, ex_busy1);
            end
            cyc();
        end
        stallreq_id = 0; #1;
        total++;
        if (stall1 !== 6'b0) begin
            bad++; $display("FAIL loaduse_release: stall=%b want 000000", stall1);
        end
        cyc();
    endtask

    // K=5 at cycle 0: held cycles 1..4, ex_done in cycle 5; stallreq_id and a second
    // ex_start are ignored while waiting
    task automatic test_ex_wait();
        ex_start = 1; ex_cycles = 5; cyc();
        ex_start = 0; ex_cycles = 0;
        for (int i = 1; i <= 4; i++) begin
            stallreq_id = (i == 2);
            ex_start = (i == 3); ex_cycles = (i == 3) ? 6'd3 : 6'd0;
            #1;
            total++;
            if (stall1 !== 6'b001111 || ex_busy1 !== 1'b1 || ex_done1 !== 1'b0) begin
                bad++; $display("FAIL ex_wait_c%0d: stall=%b busy=%b done=%b want 001111 1 0",
                                i, stall1, ex_busy1, ex_done1);
            end
            cyc();
        end
        idle(); #1;
        total++;
        if (ex_done1 !== 1'b1 || stall1 !== 6'b0 || ex_busy1 !== 1'b0) begin
            bad++; $display("FAIL ex_done_c5: done=%b stall=%b busy=%b want 1 000000 0",
                            ex_done1, stall1, ex_busy1);
        end
        cyc(); #1;
        total++;
        if (ex_done1 !== 1'b0 || ex_busy1 !== 1'b0) begin
            bad++; $display("FAIL ex_done_c6: done=%b busy=%b want 0 0", ex_done1, ex_busy1);
        end
        cyc();
    endtask

    task automatic test_single_cycle();
        for (int k = 1; k >= 0; k--) begin
            ex_start = 1; ex_cycles = 6'(k); cyc();
            idle();
            for (int j = 0; j < 2; j++) begin
                #1;
                total++;
                if (stall1 !== 6'b0 || ex_busy1 !== 1'b0 || ex_done1 !== 1'b0) begin
                    bad++; $display("FAIL single_k%0d_c%0d: stall=%b busy=%b done=%b want 0",
                                    k, j, stall1, ex_busy1, ex_done1);
                end
                cyc();
            end
        end
    endtask

    // the shortest and longest legal multi-cycle ops
    task automatic test_ex_bounds();
        int ok;
        ex_start = 1; ex_cycles = 2; cyc(); idle(); #1;
        total++;
        if (stall1 !== 6'b001111 || ex_busy1 !== 1'b1) begin
            bad++; $display("FAIL ex_k2_c1: stall=%b busy=%b want 001111 1", stall1, ex_busy1);
        end
        cyc(); #1;
        total++;
        if (ex_done1 !== 1'b1 || ex_busy1 !== 1'b0) begin
            bad++; $display("FAIL ex_k2_c2: done=%b busy=%b want 1 0", ex_done1, ex_busy1);
        end
        cyc();
        ex_start = 1; ex_cycles = 6'd63; cyc(); idle();
        ok = 1;
        for (int i = 1; i <= 62; i++) begin
            #1;
            if (ex_busy1 !== 1'b1 || ex_done1 !== 1'b0) ok = 0;
            cyc();
        end
        #1;
        total++;
        if (ok != 1 || ex_done1 !== 1'b1) begin
            bad++; $display("FAIL ex_k63: wait_ok=%0d done=%b want 1 1", ok, ex_done1);
        end
        cyc();
    endtask

    // K=8 at cycle 0 aborted by a flush at cycle 3
    task automatic test_flush_abort();
        int ok;
        ex_start = 1; ex_cycles = 8; cyc(); idle();
        cyc(); cyc();
        flush_req = 1; flush_pc = 32'h0000_0100; #1;
        total++;
        if (stall1 !== 6'b001111) begin
            bad++; $display("FAIL abort_c3: stall=%b want 001111", stall1);
        end
        cyc(); idle(); #1;
        total++;
        if (flush1 !== 1'b1 || new_pc1 !== 32'h100 || stall1 !== 6'b0 ||
            ex_busy1 !== 1'b0 || ex_done1 !== 1'b0) begin
            bad++; $display("FAIL abort_c4: fl=%b pc=%h stall=%b busy=%b done=%b want 1 100 0 0 0",
                            flush1, new_pc1, stall1, ex_busy1, ex_done1);
        end
        cyc();
        ok = 1;
        for (int i = 5; i <= 12; i++) begin
            #1;
            if (ex_done1 !== 1'b0 || flush1 !== 1'b0 || stall1 !== 6'b0) ok = 0;
            cyc();
        end
        total++;
        if (ok != 1) begin
            bad++; $display("FAIL abort_after: spurious done/flush/stall got=%0d want 1", ok);
        end
    endtask

    // two back-to-back redirects with FLUSH_CYCLES=2 (d2), newest target wins
    task automatic test_back_to_back();
        flush_req = 1; flush_pc = 32'h20; cyc();
        flush_pc = 32'h40; #1;
        total++;
        if (flush2 !== 1'b1 || new_pc2 !== 32'h20) begin
            bad++; $display("FAIL b2b_c1: fl=%b pc=%h want 1 20", flush2, new_pc2);
        end
        cyc(); idle(); stallreq_id = 1; ex_start = 1; ex_cycles = 4; #1;
        total++;
        if (flush2 !== 1'b1 || new_pc2 !== 32'h40 || stall2 !== 6'b0 || flush1 !== 1'b1) begin
            bad++; $display("FAIL b2b_c2: fl=%b pc=%h stall=%b fl1=%b want 1 40 0 1",
                            flush2, new_pc2, stall2, flush1);
        end
        cyc(); idle(); #1;
        total++;
        if (flush2 !== 1'b1 || new_pc2 !== 32'h40 || flush1 !== 1'b0 || ex_busy2 !== 1'b0) begin
            bad++; $display("FAIL b2b_c3: fl=%b pc=%h fl1=%b busy=%b want 1 40 0 0",
                            flush2, new_pc2, flush1, ex_busy2);
        end
        cyc(); #1;
        total++;
        if (flush2 !== 1'b0 || ex_busy2 !== 1'b0) begin
            bad++; $display("FAIL b2b_c4: fl=%b busy=%b want 0 0", flush2, ex_busy2);
        end
        cyc();
    endtask

    // reset in cycle 3 of a K=6 wait
    task automatic test_mid_reset();
        int ok;
        ex_start = 1; ex_cycles = 6; cyc(); idle();
        cyc(); cyc();
        rst = 1; #1;
        total++;
        if (stall1 !== 6'b0 || ex_busy1 !== 1'b0 || flush1 !== 1'b0 || ex_done1 !== 1'b0) begin
            bad++; $display("FAIL rst_mid_c3: stall=%b busy=%b fl=%b done=%b want 0",
                            stall1, ex_busy1, flush1, ex_done1);
        end
        cyc(); rst = 0; #1;
        total++;
        if ({stall1, ex_busy1, flush1, ex_done1} !== 9'b0 || new_pc1 !== 32'h0) begin
            bad++; $display("FAIL rst_mid_c4: stall=%b busy=%b fl=%b done=%b pc=%h want 0",
                            stall1, ex_busy1, flush1, ex_done1, new_pc1);
        end
        cyc();
        ok = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (ex_done1 !== 1'b0 || ex_busy1 !== 1'b0) ok = 0;
            cyc();
        end
        total++;
        if (ok != 1) begin
            bad++; $display("FAIL rst_mid_no_done: got=%0d want 1", ok);
        end
        test_loaduse();
    endtask

    initial begin
        rst = 1; idle();
        test_reset();
        test_loaduse();
        test_ex_wait();
        test_single_cycle();
        test_ex_bounds();
        test_flush_abort();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
